// File: rtl/pipeline_stage_reg.sv
// Elastic PC + instruction pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional saturating statistics counters are compiled in with PIPE_STAGE_STATS_EN.
module pipeline_stage_reg #(
   parameter int unsigned             PC_W      = 32,
   parameter int unsigned             INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]      NOP_INSTR = INSTR_W'(32'h00000013),
   parameter int unsigned             CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inValid,
   output logic               inReady,
   input  logic [PC_W-1:0]    pcIn,
   input  logic [INSTR_W-1:0] instrIn,
   input  logic               flush,
   output logic               outValid,
   input  logic               outReady,
   output logic [PC_W-1:0]    pcOut,
   output logic [INSTR_W-1:0] instrOut,
   output logic [CNT_W-1:0]   stallCycles,
   output logic [CNT_W-1:0]   bubbleCycles,
   output logic [CNT_W-1:0]   flushCount
);

   typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

   state_e               state_q, state_d;
   logic [PC_W-1:0]      main_pc_q, main_pc_d;
   logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
   logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;

   // Handshake outputs come straight from the state register.
   assign inReady  = (state_q != StSkid);
   assign outValid = (state_q != StEmpty);
   assign pcOut    = main_pc_q;
   assign instrOut = outValid ? main_instr_q : NOP_INSTR;

   always_comb begin
      state_d      = state_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      unique case (state_q)
         StEmpty: begin
            if (inValid) begin
               main_pc_d    = pcIn;
               main_instr_d = instrIn;
               state_d      = StFull;
            end
         end
         StFull: begin
            if (outReady) begin
               if (inValid) begin
                  main_pc_d    = pcIn;
                  main_instr_d = instrIn;
               end else begin
                  state_d = StEmpty;
               end
            end else if (inValid) begin
               skid_pc_d    = pcIn;
               skid_instr_d = instrIn;
               state_d      = StSkid;
            end
         end
         StSkid: begin
            if (outReady) begin
               main_pc_d    = skid_pc_q;
               main_instr_d = skid_instr_q;
               state_d      = StFull;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Flush wins: any beat accepted this cycle is dropped and pcOut keeps its value.
      if (flush) begin
         state_d      = StEmpty;
         main_pc_d    = main_pc_q;
         main_instr_d = main_instr_q;
         skid_pc_d    = skid_pc_q;
         skid_instr_d = skid_instr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StEmpty;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_q, bubble_q, flush_cnt_q;

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q     <= '0;
         bubble_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (outValid && !outReady && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
         end
         if (!outValid && (bubble_q != '1)) begin
            bubble_q <= bubble_q + 1'b1;
         end
         if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stallCycles  = stall_q;
   assign bubbleCycles = bubble_q;
   assign flushCount   = flush_cnt_q;
`else
   assign stallCycles  = '0;
   assign bubbleCycles = '0;
   assign flushCount   = '0;
`endif

endmodule
